// File: rtl/masked_and_feeder.sv
// masked_and_feeder
//   Splits one plaintext operand pair (a, b) into 3 Boolean shares each and feeds
//   them, with fresh refresh randomness, to an external masked AND gadget. It
//   waits for the gadget to finish, holds the result shares until they are
//   consumed, and then clears all share registers before the next operand.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   a_in, b_in, in_valid  plaintext operand bits and their valid strobe
//   in_ready              high while idle (operand can be accepted)
//   ina, inb              operand shares to the gadget (index 0 = masked share)
//   rin                   gadget refresh randomness {r6, r5, r4}
//   and_enable            gadget enable, high only while waiting for the gadget
//   and_done, and_out     gadget completion flag and result shares
//   res_shares            captured result shares
//   res_valid, res_ready  result handshake
//   err                   sticky gadget timeout flag, cleared only by reset
module masked_and_feeder #(
  parameter int          D       = 3,
  parameter logic [31:0] SEED    = 32'hACE12468,
  parameter int          TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_in,
  input  logic                   b_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [D-1:0]           ina,
  output logic [D-1:0]           inb,
  output logic [D*(D-1)/2-1:0]   rin,
  output logic                   and_enable,
  input  logic                   and_done,
  input  logic [D-1:0]           and_out,
  output logic [D-1:0]           res_shares,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   err
);

  localparam logic [31:0] TAPS = 32'h80200003;
  localparam int          CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GATHER,
    LOAD,
    RUN,
    HOLD,
    CLEAR,
    ERR
  } state_t;

  state_t        state;
  logic [31:0]   lfsr;
  logic [6:0]    r;
  logic [2:0]    gcnt;
  logic [CW-1:0] run_cnt;
  logic          a_q;
  logic          b_q;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= SEED;
      r          <= '0;
      gcnt       <= '0;
      run_cnt    <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      ina        <= '0;
      inb        <= '0;
      rin        <= '0;
      res_shares <= '0;
      and_enable <= 1'b0;
      res_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a_in;
            b_q   <= b_in;
            gcnt  <= '0;
            state <= GATHER;
          end
        end

        // One Galois LFSR step per cycle; r[0] is the first bit drawn.
        GATHER: begin
          r[gcnt] <= lfsr[0];
          lfsr    <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : '0);
          gcnt    <= gcnt + 3'd1;
          if (gcnt == 3'd6) begin
            state <= LOAD;
          end
        end

        // Share vectors are written MSB-first, so index 0 is the rightmost term.
        LOAD: begin
          ina        <= {r[1], r[0], a_q ^ r[0] ^ r[1]};
          inb        <= {r[3], r[2], b_q ^ r[2] ^ r[3]};
          rin        <= r[6:4];
          and_enable <= 1'b1;
          run_cnt    <= '0;
          state      <= RUN;
        end

        // run_cnt holds the number of completed RUN cycles; done wins over
        // the timeout on the last allowed cycle.
        RUN: begin
          if (and_done) begin
            res_shares <= and_out;
            res_valid  <= 1'b1;
            and_enable <= 1'b0;
            state      <= HOLD;
          end else if (run_cnt == CW'(TIMEOUT - 1)) begin
            ina        <= '0;
            inb        <= '0;
            rin        <= '0;
            res_shares <= '0;
            and_enable <= 1'b0;
            err        <= 1'b1;
            state      <= ERR;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (res_ready) begin
            ina        <= '0;
            inb        <= '0;
            rin        <= '0;
            res_shares <= '0;
            res_valid  <= 1'b0;
            state      <= CLEAR;
          end
        end

        CLEAR: begin
          state <= IDLE;
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_and_feeder.sv
// tb_masked_and_feeder
//   Scoreboard bench for masked_and_feeder. A behavioural gadget model produces
//   done after a configurable number of enabled cycles; expected shares are
//   predicted from an independent LFSR model at operand acceptance and compared
//   when res_valid rises.
module tb_masked_and_feeder;

  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       in_ready;
  logic       and_enable;
  logic       and_done;
  logic       res_valid;
  logic       err;
  logic [2:0] ina;
  logic [2:0] inb;
  logic [2:0] rin;
  logic [2:0] and_out;
  logic [2:0] res_shares;

  masked_and_feeder #(.D(3), .SEED(SEED), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ina        (ina),
    .inb        (inb),
    .rin        (rin),
    .and_enable (and_enable),
    .and_done   (and_done),
    .and_out    (and_out),
    .res_shares (res_shares),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Gadget model: done on the done_at-th consecutive enabled cycle (0 = never).
  int   done_at = 3;
  int   en_cnt = 0;
  int   en_total = 0;
  logic done_noise = 1'b0;

  always @(posedge clk) begin
    if (and_enable) begin
      en_cnt   <= en_cnt + 1;
      en_total <= en_total + 1;
    end else begin
      en_cnt <= 0;
    end
  end

  assign and_done = done_noise | (and_enable && done_at != 0 && en_cnt == done_at - 1);
  assign and_out  = {rin[1], rin[0], ((^ina) & (^inb)) ^ rin[0] ^ rin[1]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] ina;
    logic [2:0] inb;
    logic [2:0] rin;
    logic [2:0] res;
    logic       ab;
    int         acc;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] lfsr_m = SEED;

  task automatic predict(input logic a, input logic b, output exp_t e);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) begin
      r[i]   = lfsr_m[0];
      lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? TAPS : 32'h0);
    end
    e.ina = {r[1], r[0], a ^ r[0] ^ r[1]};
    e.inb = {r[3], r[2], b ^ r[2] ^ r[3]};
    e.rin = r[6:4];
    e.res = {r[5], r[4], (a & b) ^ r[4] ^ r[5]};
    e.ab  = a & b;
    e.acc = cyc;
    e.lat = 9 + done_at;
  endtask

  // Monitor
  logic       prev_rv = 1'b0;
  logic [2:0] last_ina, last_inb, last_rin, last_res;
  int         results = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (and_enable && sb.size() > 0) begin
      check_eq("run_ina", 32'(ina), 32'(sb[0].ina));
      check_eq("run_inb", 32'(inb), 32'(sb[0].inb));
      check_eq("run_rin", 32'(rin), 32'(sb[0].rin));
    end
    if (res_valid && !prev_rv) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_res_valid", 32'(1), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check_eq("res_shares", 32'(res_shares), 32'(mon_e.res));
        check_eq("res_xor", 32'(^res_shares), 32'(mon_e.ab));
        check_eq("hold_ina", 32'(ina), 32'(mon_e.ina));
        check_eq("hold_inb", 32'(inb), 32'(mon_e.inb));
        check_eq("hold_rin", 32'(rin), 32'(mon_e.rin));
        check_eq("hold_enable", 32'(and_enable), 32'(0));
        check_eq("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        last_ina = ina;
        last_inb = inb;
        last_rin = rin;
        last_res = res_shares;
        results++;
      end
    end
    if (!res_valid && prev_rv && rst_n) begin
      check_eq("clear_zero", 32'({ina, inb, rin, res_shares, in_ready}), 32'(0));
    end
    prev_rv = res_valid;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 32'(0), 32'(1));
  endtask

  task automatic drive(input logic a, input logic b, input bit push);
    exp_t e;
    wait_ready();
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    predict(a, b, e);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    logic [11:0] snap;
    logic [1:0]  p;
    int          n;
    int          t0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));
    check_eq("rst_res_valid", 32'(res_valid), 32'(0));
    check_eq("rst_err", 32'(err), 32'(0));
    check_eq("rst_enable", 32'(and_enable), 32'(0));
    check_eq("rst_shares", 32'({ina, inb, rin, res_shares}), 32'(0));
    rst_n = 1'b1;

    // First transaction a=1,b=1 from SEED
    res_ready = 1'b1;
    done_at   = 3;
    drive(1'b1, 1'b1, 1'b1);
    drain();
    check_eq("first_ina", 32'(last_ina), 32'(3'b001));
    check_eq("first_inb", 32'(last_inb), 32'(3'b100));
    check_eq("first_rin", 32'(last_rin), 32'(3'b111));
    check_eq("first_res", 32'(last_res), 32'(3'b111));

    // All four operand pairs back-to-back
    for (int i = 0; i < 4; i++) begin
      p = 2'(i);
      drive(p[1], p[0], 1'b1);
    end
    drain();
    check_eq("results_count", 32'(results), 32'(5));

    // Result held with res_ready low; spurious done outside RUN ignored
    res_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("hold_reached", 32'(res_valid), 32'(1));
    snap       = {res_shares, ina, inb, rin};
    done_noise = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_stable", 32'({res_shares, ina, inb, rin}), 32'(snap));
      check_eq("hold_in_ready", 32'(in_ready), 32'(0));
      check_eq("hold_valid", 32'(res_valid), 32'(1));
    end
    done_noise = 1'b0;
    res_ready  = 1'b1;
    drain();

    // Done on the last allowed RUN cycle
    done_at = 8;
    drive(1'b1, 1'b0, 1'b1);
    drain();
    check_eq("late_done_err", 32'(err), 32'(0));
    check_eq("results_count2", 32'(results), 32'(7));

    // Gadget never finishes -> timeout
    done_at = 0;
    t0      = en_total;
    drive(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!err && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_err", 32'(err), 32'(1));
    check_eq("timeout_run_cycles", 32'(en_total - t0), 32'(8));
    check_eq("timeout_enable", 32'(and_enable), 32'(0));
    check_eq("timeout_shares", 32'({ina, inb, rin, res_shares}), 32'(0));
    repeat (5) @(negedge clk);
    check_eq("err_sticky", 32'(err), 32'(1));
    check_eq("err_in_ready", 32'(in_ready), 32'(0));
    rst_n  = 1'b0;
    lfsr_m = SEED;
    sb.delete();
    #1;
    check_eq("err_rst_in_ready", 32'(in_ready), 32'(1));
    check_eq("err_rst_err", 32'(err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during GATHER cycle 4, then a=1,b=0 reuses SEED randomness
    done_at = 3;
    drive(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n  = 1'b0;
    lfsr_m = SEED;
    sb.delete();
    #1;
    check_eq("abort_in_ready", 32'(in_ready), 32'(1));
    check_eq("abort_res_valid", 32'(res_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    drain();
    check_eq("seed_ina", 32'(last_ina), 32'(3'b001));
    check_eq("seed_inb", 32'(last_inb), 32'(3'b101));
    check_eq("seed_rin", 32'(last_rin), 32'(3'b111));
    check_eq("seed_res", 32'(last_res), 32'(3'b110));
    check_eq("results_count3", 32'(results), 32'(8));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
